// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity modes and the
// parity helper, so the receiver computes parity exactly the same way.
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   // Unused upper bits must be zero so they do not disturb the XOR.
   function automatic logic uart_parity(input logic [8:0] data, input int mode);
      logic p;
      case (mode)
         PARITY_EVEN: p = ^data;
         PARITY_ODD:  p = ~^data;
         default:     p = 1'b0;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/uart_tx_tick.sv
// UART transmitter driven by an external bit-period tick: start bit, LSB-first
// data, optional parity, then one or two stop bits.
module uart_tx_tick #(
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_tick,
   input  logic [DATA_BITS-1:0] i_data,
   input  logic                 i_valid,
   output logic                 o_ready,
   output logic                 o_txd,
   output logic                 o_busy,
   output logic                 o_done
);
   import uart_pkg::*;

   localparam int               CNT_W     = $clog2(DATA_BITS + 1);
   localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
   localparam logic [1:0]       LAST_STOP = 2'(STOP_BITS);

   uart_tx_state_t       state;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bit;
   logic [CNT_W-1:0]     bit_cnt;
   logic [1:0]           stop_cnt;

   assign o_ready = (state == IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         shreg    <= '0;
         par_bit  <= 1'b0;
         bit_cnt  <= '0;
         stop_cnt <= '0;
         o_txd    <= 1'b1;
         o_busy   <= 1'b0;
         o_done   <= 1'b0;
      end else begin
         o_done <= 1'b0;
         case (state)
            IDLE: begin
               // Ticks here are ignored; the start bit waits for the next tick.
               if (i_valid) begin
                  shreg   <= i_data;
                  par_bit <= uart_parity(9'(i_data), PARITY);
                  o_busy  <= 1'b1;
                  state   <= START;
               end
            end
            START: begin
               if (i_tick) begin
                  o_txd   <= 1'b0;
                  bit_cnt <= '0;
                  state   <= DATA;
               end
            end
            DATA: begin
               if (i_tick) begin
                  o_txd   <= shreg[0];
                  shreg   <= shreg >> 1;
                  bit_cnt <= bit_cnt + CNT_W'(1);
                  if (bit_cnt == LAST_BIT) begin
                     stop_cnt <= '0;
                     state    <= (PARITY != PARITY_NONE) ? uart_pkg::PARITY : STOP;
                  end
               end
            end
            uart_pkg::PARITY: begin
               if (i_tick) begin
                  o_txd    <= par_bit;
                  stop_cnt <= '0;
                  state    <= STOP;
               end
            end
            STOP: begin
               // The tick after the last stop drive closes the frame.
               if (i_tick) begin
                  if (stop_cnt == LAST_STOP) begin
                     o_busy <= 1'b0;
                     o_done <= 1'b1;
                     state  <= IDLE;
                  end else begin
                     o_txd    <= 1'b1;
                     stop_cnt <= stop_cnt + 2'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_tick.sv
// Directed bench for uart_tx_tick: four parameterisations share one stimulus.
module tb_uart_tx_tick;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   logic [7:0] data = 8'h00;
   logic       valid = 1'b0;

   logic ready0, txd0, busy0, done0;
   logic ready1, txd1, busy1, done1;
   logic ready2, txd2, busy2, done2;
   logic ready3, txd3, busy3, done3;

   logic [11:0] rec0, rec1, rec2, rec3;
   logic [11:0] brec0, brec3;
   int dc0 = 0, dc1 = 0, dc2 = 0, dc3 = 0;
   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   uart_tx_tick #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) d0 (
      .clk(clk), .rst(rst), .i_tick(tick), .i_data(data), .i_valid(valid),
      .o_ready(ready0), .o_txd(txd0), .o_busy(busy0), .o_done(done0));
   uart_tx_tick #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) d1 (
      .clk(clk), .rst(rst), .i_tick(tick), .i_data(data), .i_valid(valid),
      .o_ready(ready1), .o_txd(txd1), .o_busy(busy1), .o_done(done1));
   uart_tx_tick #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) d2 (
      .clk(clk), .rst(rst), .i_tick(tick), .i_data(data), .i_valid(valid),
      .o_ready(ready2), .o_txd(txd2), .o_busy(busy2), .o_done(done2));
   uart_tx_tick #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) d3 (
      .clk(clk), .rst(rst), .i_tick(tick), .i_data(data), .i_valid(valid),
      .o_ready(ready3), .o_txd(txd3), .o_busy(busy3), .o_done(done3));

   always @(negedge clk) begin
      if (done0) dc0++;
      if (done1) dc1++;
      if (done2) dc2++;
      if (done3) dc3++;
   end

   task automatic run_ticks(input int n);
      rec0 = '0; rec1 = '0; rec2 = '0; rec3 = '0; brec0 = '0; brec3 = '0;
      for (int k = 0; k < n; k++) begin
         repeat (3) @(negedge clk);
         tick = 1'b1;
         @(negedge clk);
         tick = 1'b0;
         rec0  = {rec0[10:0], txd0};
         rec1  = {rec1[10:0], txd1};
         rec2  = {rec2[10:0], txd2};
         rec3  = {rec3[10:0], txd3};
         brec0 = {brec0[10:0], busy0};
         brec3 = {brec3[10:0], busy3};
      end
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      data  = b;
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({txd0, busy0, done0, ready0} !== 4'b1001) begin
         n_fail++; $display("FAIL reset_d0: got %b expected 1001", {txd0, busy0, done0, ready0});
      end
      n_checks++;
      if ({txd3, busy3, done3, ready3} !== 4'b1001) begin
         n_fail++; $display("FAIL reset_d3: got %b expected 1001", {txd3, busy3, done3, ready3});
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_idle_ticks;
      run_ticks(3);
      n_checks++;
      if ({rec0[2:0], brec0[2:0], ready0} !== 7'b1110001) begin
         n_fail++; $display("FAIL idle_ticks: got %b expected 1110001", {rec0[2:0], brec0[2:0], ready0});
      end
   endtask

   task automatic test_basic_parity;
      int s0, s1, s2, s3;
      s0 = dc0; s1 = dc1; s2 = dc2; s3 = dc3;
      send(8'hA5);
      n_checks++;
      if ({txd0, busy0, ready0} !== 3'b110) begin
         n_fail++; $display("FAIL accept_a5: got %b expected 110", {txd0, busy0, ready0});
      end
      run_ticks(12);
      n_checks++;
      if (rec0 !== 12'b010100101111) begin
         n_fail++; $display("FAIL a5_none_txd: got %b expected 010100101111", rec0);
      end
      n_checks++;
      if (rec1 !== 12'b010100101011) begin
         n_fail++; $display("FAIL a5_even_txd: got %b expected 010100101011", rec1);
      end
      n_checks++;
      if (rec2 !== 12'b010100101111) begin
         n_fail++; $display("FAIL a5_odd_txd: got %b expected 010100101111", rec2);
      end
      n_checks++;
      if (brec0 !== 12'b111111111100) begin
         n_fail++; $display("FAIL a5_none_busy: got %b expected 111111111100", brec0);
      end
      n_checks++;
      if (ready0 !== 1'b1) begin
         n_fail++; $display("FAIL a5_ready_back: got %b expected 1", ready0);
      end
      @(negedge clk);
      n_checks++;
      if ({dc0 - s0, dc1 - s1, dc2 - s2, dc3 - s3} !== {32'd1, 32'd1, 32'd1, 32'd1}) begin
         n_fail++; $display("FAIL a5_done_count: got %0d %0d %0d %0d expected 1 1 1 1",
                            dc0 - s0, dc1 - s1, dc2 - s2, dc3 - s3);
      end
      send(8'h01);
      run_ticks(12);
      n_checks++;
      if (rec1 !== 12'b010000000111) begin
         n_fail++; $display("FAIL 01_even_txd: got %b expected 010000000111", rec1);
      end
      n_checks++;
      if (rec2 !== 12'b010000000011) begin
         n_fail++; $display("FAIL 01_odd_txd: got %b expected 010000000011", rec2);
      end
   endtask

   task automatic test_stop2;
      send(8'h00);
      run_ticks(12);
      n_checks++;
      if (rec3 !== 12'b000000000111) begin
         n_fail++; $display("FAIL stop2_txd: got %b expected 000000000111", rec3);
      end
      n_checks++;
      if (brec3 !== 12'b111111111110) begin
         n_fail++; $display("FAIL stop2_busy: got %b expected 111111111110", brec3);
      end
      n_checks++;
      if (ready3 !== 1'b1) begin
         n_fail++; $display("FAIL stop2_ready: got %b expected 1", ready3);
      end
   endtask

   task automatic test_tick_accept;
      @(negedge clk);
      data  = 8'h5A;
      valid = 1'b1;
      tick  = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      tick  = 1'b0;
      n_checks++;
      if ({txd0, busy0} !== 2'b11) begin
         n_fail++; $display("FAIL tick_accept_line: got %b expected 11", {txd0, busy0});
      end
      run_ticks(12);
      n_checks++;
      if (rec0 !== 12'b001011010111) begin
         n_fail++; $display("FAIL tick_accept_txd: got %b expected 001011010111", rec0);
      end
   endtask

   task automatic test_back_to_back;
      int s0;
      s0 = dc0;
      @(negedge clk);
      data  = 8'h11;
      valid = 1'b1;
      @(negedge clk);
      data  = 8'h22;
      run_ticks(11);
      n_checks++;
      if (rec0[10:0] !== 11'b01000100011) begin
         n_fail++; $display("FAIL b2b_frame1: got %b expected 01000100011", rec0[10:0]);
      end
      n_checks++;
      if (brec0[0] !== 1'b0) begin
         n_fail++; $display("FAIL b2b_idle_between: got busy %b expected 0", brec0[0]);
      end
      @(negedge clk);
      n_checks++;
      if (busy0 !== 1'b1) begin
         n_fail++; $display("FAIL b2b_second_accept: got busy %b expected 1", busy0);
      end
      valid = 1'b0;
      data  = 8'h33;
      run_ticks(11);
      n_checks++;
      if (rec0[10:0] !== 11'b00100010011) begin
         n_fail++; $display("FAIL b2b_frame2: got %b expected 00100010011", rec0[10:0]);
      end
      @(negedge clk);
      n_checks++;
      if (dc0 - s0 !== 2) begin
         n_fail++; $display("FAIL b2b_done_count: got %0d expected 2", dc0 - s0);
      end
   endtask

   task automatic test_reset_mid;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      send(8'hF7);
      run_ticks(5);
      n_checks++;
      if ({txd0, busy0} !== 2'b01) begin
         n_fail++; $display("FAIL mid_before_reset: got %b expected 01", {txd0, busy0});
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({txd0, busy0, ready0, txd1, busy1} !== 5'b10110) begin
         n_fail++; $display("FAIL mid_async_reset: got %b expected 10110", {txd0, busy0, ready0, txd1, busy1});
      end
      @(negedge clk);
      rst = 1'b0;
      send(8'h5A);
      run_ticks(12);
      n_checks++;
      if (rec0 !== 12'b001011010111) begin
         n_fail++; $display("FAIL after_reset_none: got %b expected 001011010111", rec0);
      end
      n_checks++;
      if (rec1 !== 12'b001011010011) begin
         n_fail++; $display("FAIL after_reset_even: got %b expected 001011010011", rec1);
      end
   endtask

   initial begin
      test_reset();
      test_idle_ticks();
      test_basic_parity();
      test_stop2();
      test_tick_accept();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
